mux_scan_nto1: RTL and testbench
================================

Name: mux_scan_nto1

Overview:
Parametrised, registered N:1 multiplexer for WIDTH-bit channels, with two modes. In manual mode the output follows an externally driven select. In scan mode the block time-division multiplexes all channels itself, staying on each channel for a programmable dwell. It sits between grouped sensor or status lanes and a single shared downstream consumer (display, serialiser, logger).

Parameters:
WIDTH, 1, bits per channel (>=1)
N, 4, number of input channels (2..256)
SELW, 2, select/counter width; must equal ceil(log2(N)), minimum 1
DWELL, 4, cycles spent on each channel in scan mode (1..65535)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_bus  input  N*WIDTH  packed channels; channel k = in_bus[k*WIDTH +: WIDTH]
sel  input  SELW  channel select, used in manual mode only
mode  input  1  0 = manual, 1 = scan
en  input  1  block enable
y  output  WIDTH  registered selected channel data
y_valid  output  1  y holds a valid sample this cycle
cur_sel  output  SELW  channel index that produced the current y
frame_done  output  1  one-cycle pulse on the last sample of channel N-1 in scan mode

Behaviour:
- One clock; reset asynchronous, active-low. While rst_n=0: y=0, y_valid=0, cur_sel=0, frame_done=0, state=IDLE, channel counter ch=0, dwell counter dw=0.
- All outputs are registered. Latency from in_bus/sel sampled to y is 1 cycle.
- States: IDLE, MANUAL, SCAN. Next state is evaluated every cycle:
  - en=0 -> IDLE.
  - en=1 and mode=0 -> MANUAL.
  - en=1 and mode=1 -> SCAN.
- IDLE: y and cur_sel hold their last value; y_valid=0; frame_done=0; ch and dw cleared to 0.
- MANUAL: y <= channel[sel], cur_sel <= sel, y_valid <= 1.
  - If sel >= N (non-power-of-2 N): y <= 0, cur_sel <= sel, y_valid <= 0.
  - ch and dw are held at 0.
- SCAN:
  - Each cycle: y <= channel[ch], cur_sel <= ch, y_valid <= 1.
  - dw counts 0..DWELL-1. When dw = DWELL-1: dw <= 0 and ch advances.
  - ch wraps N-1 -> 0.
  - frame_done <= 1 in the cycle whose y is the final dwell sample of channel N-1; 0 otherwise.
  - DWELL=1: channel changes every cycle; frame_done asserts once every N cycles.
- Entering SCAN from IDLE or MANUAL always starts at ch=0, dw=0. The first scan sample appears 1 cycle after the first cycle with mode=1 and en=1.
- Mode switch SCAN -> MANUAL mid-dwell: the scan position is discarded; the next y is channel[sel]; no frame_done.
- en deassert mid-scan: y_valid drops on the next edge; a later re-enable restarts at channel 0.
- Input changes within a dwell are tracked every cycle; y is not latched per dwell.
- Reset asserted mid-operation forces reset values immediately (asynchronous). Release is synchronous to the next clk edge, starting in IDLE.
- dw counter width: enough to hold DWELL-1 (max 16 bits). No other arithmetic.

Optional Feature:
Macro: MUX_SCAN_PARITY_EN
- Defined: adds output y_par (1 bit). y_par is the even parity (XOR reduction) of the value loaded into y, registered on the same edge as y. Reset value 0; held in IDLE together with y. When sel >= N, y_par = 0.
- Not defined: port y_par and its logic are absent; all other behaviour is identical.

Test Plan:
- N=4, WIDTH=1, in_bus=4'b0110 (ch0=0, ch1=1, ch2=1, ch3=0), en=1, mode=0, sel stepped 0,1,2,3 one per cycle -> one cycle later y=0,1,1,0, cur_sel=0,1,2,3, y_valid=1, frame_done=0 throughout.
- Same inputs, mode=1, DWELL=2 -> y sequence 0,0,1,1,1,1,0,0 repeating; cur_sel 0,0,1,1,2,2,3,3; frame_done=1 only on the 8th sample of each frame.
- N=3, WIDTH=4, mode=0, sel=3 -> y=0, y_valid=0, cur_sel=3; sel=2 with ch2=4'hA -> y=4'hA, y_valid=1 next cycle.
- Scan running at ch=2, dw=1: pulse rst_n low mid-cycle -> y, y_valid, cur_sel and frame_done go to 0 immediately. After release with en=1, mode=1 -> scan restarts at ch0.
- Scan at ch=3: switch mode to 0 with sel=1 -> next y=ch1 value, frame_done never pulses. Switch back to mode=1 -> first sample comes from ch0.
- With MUX_SCAN_PARITY_EN, WIDTH=4, ch0=4'b1011 selected -> y_par=1; ch1=4'b0110 -> y_par=0, aligned with y.

Source files
------------

// File: rtl/mux_scan_nto1_if.sv
// Channel bus, select/mode controls and registered result for mux_scan_nto1.
// y_par exists only when MUX_SCAN_PARITY_EN is defined.
interface mux_scan_nto1_if #(
    parameter int N     = 4,
    parameter int WIDTH = 1,
    parameter int SELW  = 2
);
    logic [N*WIDTH-1:0] in_bus;
    logic [SELW-1:0]    sel;
    logic               mode;
    logic               en;
    logic [WIDTH-1:0]   y;
    logic               y_valid;
    logic [SELW-1:0]    cur_sel;
    logic               frame_done;
`ifdef MUX_SCAN_PARITY_EN
    logic               y_par;

    modport master (
        output in_bus, sel, mode, en,
        input  y, y_valid, cur_sel, frame_done, y_par
    );
    modport slave (
        input  in_bus, sel, mode, en,
        output y, y_valid, cur_sel, frame_done, y_par
    );
`else
    modport master (
        output in_bus, sel, mode, en,
        input  y, y_valid, cur_sel, frame_done
    );
    modport slave (
        input  in_bus, sel, mode, en,
        output y, y_valid, cur_sel, frame_done
    );
`endif
endinterface

// File: rtl/mux_scan_nto1.sv
// Registered N:1 mux with manual select and self-timed channel scan.
// Optional even-parity output y_par under MUX_SCAN_PARITY_EN.
module mux_scan_nto1 #(
    parameter int WIDTH = 1,
    parameter int N     = 4,
    parameter int SELW  = 2,
    parameter int DWELL = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    mux_scan_nto1_if.slave  bus
);
    localparam int DWW = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {
        IDLE,
        MANUAL,
        SCAN
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             y_valid_q, y_valid_d;
    logic [SELW-1:0]  cur_sel_q, cur_sel_d;
    logic             frame_done_q, frame_done_d;
    logic [SELW-1:0]  ch_q, ch_d;
    logic [DWW-1:0]   dw_q, dw_d;
    logic [SELW-1:0]  scan_ch;
    logic [DWW-1:0]   scan_dw;

    function automatic logic [WIDTH-1:0] pick(
        input logic [SELW-1:0]    idx,
        input logic [N*WIDTH-1:0] v
    );
        pick = '0;
        for (int k = 0; k < N; k++) begin
            if (idx == SELW'(k)) pick = v[k*WIDTH +: WIDTH];
        end
    endfunction

    always_comb begin
        state_d      = state_q;
        y_d          = y_q;
        y_valid_d    = 1'b0;
        cur_sel_d    = cur_sel_q;
        frame_done_d = 1'b0;
        ch_d         = '0;
        dw_d         = '0;
        // Any cycle not already in SCAN restarts the scan at channel 0.
        scan_ch      = (state_q == SCAN) ? ch_q : '0;
        scan_dw      = (state_q == SCAN) ? dw_q : '0;
        unique case (1'b1)
            !bus.en: begin
                state_d = IDLE;
            end
            bus.en && !bus.mode: begin
                state_d   = MANUAL;
                cur_sel_d = bus.sel;
                if (32'(bus.sel) < N) begin
                    y_d       = pick(bus.sel, bus.in_bus);
                    y_valid_d = 1'b1;
                end else begin
                    y_d = '0;
                end
            end
            bus.en && bus.mode: begin
                state_d   = SCAN;
                y_d       = pick(scan_ch, bus.in_bus);
                cur_sel_d = scan_ch;
                y_valid_d = 1'b1;
                if (scan_dw == DWW'(DWELL - 1)) begin
                    dw_d         = '0;
                    frame_done_d = (scan_ch == SELW'(N - 1));
                    ch_d         = frame_done_d ? '0 : scan_ch + 1'b1;
                end else begin
                    dw_d = scan_dw + 1'b1;
                    ch_d = scan_ch;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            y_q          <= '0;
            y_valid_q    <= 1'b0;
            cur_sel_q    <= '0;
            frame_done_q <= 1'b0;
            ch_q         <= '0;
            dw_q         <= '0;
        end else begin
            state_q      <= state_d;
            y_q          <= y_d;
            y_valid_q    <= y_valid_d;
            cur_sel_q    <= cur_sel_d;
            frame_done_q <= frame_done_d;
            ch_q         <= ch_d;
            dw_q         <= dw_d;
        end
    end

    assign bus.y          = y_q;
    assign bus.y_valid    = y_valid_q;
    assign bus.cur_sel    = cur_sel_q;
    assign bus.frame_done = frame_done_q;

`ifdef MUX_SCAN_PARITY_EN
    logic y_par_q, y_par_d;

    always_comb begin
        y_par_d = bus.en ? ^y_d : y_par_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_par_q <= 1'b0;
        end else begin
            y_par_q <= y_par_d;
        end
    end

    assign bus.y_par = y_par_q;
`endif

endmodule

// File: tb/tb_mux_scan_nto1.sv
// Bench for mux_scan_nto1: two instances (N=4/DWELL=2, N=3/DWELL=1)
// against a cycle-count based reference model.
module tb_mux_scan_nto1;
    localparam int W  = 4;
    localparam int N0 = 4;
    localparam int D0 = 2;
    localparam int N1 = 3;
    localparam int D1 = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux_scan_nto1_if #(.N(N0), .WIDTH(W), .SELW(2)) b0 ();
    mux_scan_nto1_if #(.N(N1), .WIDTH(W), .SELW(2)) b1 ();

    mux_scan_nto1 #(.WIDTH(W), .N(N0), .SELW(2), .DWELL(D0)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(b0.slave)
    );
    mux_scan_nto1 #(.WIDTH(W), .N(N1), .SELW(2), .DWELL(D1)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(b1.slave)
    );

    int n_chk = 0;
    int n_pass = 0;

    int         nch[2] = '{N0, N1};
    int         dwl[2] = '{D0, D1};
    logic [W-1:0] chv[2][4];
    logic [1:0] sv[2];
    logic       en_s = 1'b0;
    logic       mode_s = 1'b0;

    logic [W-1:0] m_y[2];
    logic [1:0]   m_cs[2];
    logic         m_v[2];
    logic         m_fd[2];
    int           m_k[2];
    logic         m_sc[2];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_y[i] = '0; m_cs[i] = '0; m_v[i] = 1'b0;
            m_fd[i] = 1'b0; m_k[i] = 0; m_sc[i] = 1'b0;
        end
    endtask

    // Scan position is derived from cycles spent in scan since entry.
    task automatic model_step();
        int c;
        for (int i = 0; i < 2; i++) begin
            if (!en_s) begin
                m_v[i] = 1'b0; m_fd[i] = 1'b0; m_sc[i] = 1'b0;
            end else if (!mode_s) begin
                m_sc[i] = 1'b0; m_fd[i] = 1'b0; m_cs[i] = sv[i];
                if (int'(sv[i]) < nch[i]) begin
                    m_y[i] = chv[i][sv[i]]; m_v[i] = 1'b1;
                end else begin
                    m_y[i] = '0; m_v[i] = 1'b0;
                end
            end else begin
                if (!m_sc[i]) m_k[i] = 0;
                c = (m_k[i] / dwl[i]) % nch[i];
                m_y[i] = chv[i][c];
                m_cs[i] = 2'(c);
                m_v[i] = 1'b1;
                m_fd[i] = (m_k[i] % (nch[i]*dwl[i])) == nch[i]*dwl[i]-1;
                m_k[i]++;
                m_sc[i] = 1'b1;
            end
        end
    endtask

    task automatic apply();
        b0.in_bus = {chv[0][3], chv[0][2], chv[0][1], chv[0][0]};
        b1.in_bus = {chv[1][2], chv[1][1], chv[1][0]};
        b0.sel = sv[0]; b1.sel = sv[1];
        b0.en = en_s; b1.en = en_s;
        b0.mode = mode_s; b1.mode = mode_s;
    endtask

    task automatic compare();
        check("y0", 32'(b0.y), 32'(m_y[0]));
        check("valid0", 32'(b0.y_valid), 32'(m_v[0]));
        check("cur_sel0", 32'(b0.cur_sel), 32'(m_cs[0]));
        check("frame0", 32'(b0.frame_done), 32'(m_fd[0]));
        check("y1", 32'(b1.y), 32'(m_y[1]));
        check("valid1", 32'(b1.y_valid), 32'(m_v[1]));
        check("cur_sel1", 32'(b1.cur_sel), 32'(m_cs[1]));
        check("frame1", 32'(b1.frame_done), 32'(m_fd[1]));
`ifdef MUX_SCAN_PARITY_EN
        check("par0", 32'(b0.y_par), 32'(^m_y[0]));
        check("par1", 32'(b1.y_par), 32'(^m_y[1]));
`endif
    endtask

    task automatic rnd_data();
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 4; c++) chv[i][c] = W'($urandom);
            sv[i] = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic cycle();
        apply();
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic mid_reset();
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        compare();
        #2 rst_n = 1'b1;
    endtask

    initial begin
        rnd_data();
        apply();
        model_reset();
        #12;
        compare();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Manual stepping with ch0..3 = 0,1,1,0
        chv[0][0] = 4'h0; chv[0][1] = 4'h1;
        chv[0][2] = 4'h1; chv[0][3] = 4'h0;
        en_s = 1'b1; mode_s = 1'b0;
        for (int s = 0; s < 4; s++) begin
            sv[0] = 2'(s); sv[1] = 2'(s);
            cycle();
        end

        // Scan over two frames, same data
        mode_s = 1'b1;
        for (int s = 0; s < 16; s++) cycle();

        // Reset pulse mid-scan, then restart
        mode_s = 1'b0; cycle();
        mode_s = 1'b1;
        for (int s = 0; s < 6; s++) cycle();
        mid_reset();
        for (int s = 0; s < 5; s++) cycle();

        // Scan -> manual sel=1 -> scan again
        sv[0] = 2'd1; sv[1] = 2'd1;
        mode_s = 1'b0;
        for (int s = 0; s < 3; s++) cycle();
        mode_s = 1'b1;
        for (int s = 0; s < 10; s++) cycle();

        // Enable drop mid-scan and re-enable
        en_s = 1'b0;
        for (int s = 0; s < 3; s++) cycle();
        en_s = 1'b1;
        for (int s = 0; s < 6; s++) cycle();

        // Randomized run
        for (int s = 0; s < 400; s++) begin
            rnd_data();
            if ($urandom_range(0, 15) == 0) en_s = ~en_s;
            if ($urandom_range(0, 9) == 0) mode_s = ~mode_s;
            if (!en_s && $urandom_range(0, 3) == 0) en_s = 1'b1;
            cycle();
            if ($urandom_range(0, 99) == 0) mid_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
